// File: rtl/btn_cmd_frontend.sv
// Board input front end: synchronises buttons/switches, debounces each button and
// merges near-simultaneous presses into a single one-cycle command pulse.
module btn_cmd_frontend #(
    parameter int BTN_BITS        = 4,
    parameter int SW_BITS         = 8,
    parameter int DEBOUNCE_CYCLES = 65536,
    parameter int CHORD_CYCLES    = 262144
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [BTN_BITS-1:0] btn_raw,
    input  logic [SW_BITS-1:0]  sw_raw,
    output logic [BTN_BITS-1:0] btn,
    output logic [SW_BITS-1:0]  sw,
    output logic                cmd_valid,
    output logic [BTN_BITS-1:0] cmd_btn,
    output logic [SW_BITS-1:0]  cmd_sw,
    output logic                busy
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam int TMR_W = $clog2(CHORD_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CHORD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        HOLD
    } state_t;

    logic [BTN_BITS-1:0] btn_s1;
    logic [BTN_BITS-1:0] btn_sync;
    logic [SW_BITS-1:0]  sw_s1;
    logic [CNT_W-1:0]    cnt [BTN_BITS];

    state_t              state, state_nxt;
    logic [BTN_BITS-1:0] chord, chord_nxt;
    logic [TMR_W-1:0]    timer, timer_nxt;
    logic                emit;

    // NOTE: registers use non-blocking assignments so every flop samples the pre-edge
    // value of its source; blocking here would collapse the two sync stages into one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_s1   <= '0;
            btn_sync <= '0;
            sw_s1    <= '0;
            sw       <= '0;
        end else begin
            btn_s1   <= btn_raw;
            btn_sync <= btn_s1;
            sw_s1    <= sw_raw;
            sw       <= sw_s1;
        end
    end

    // NOTE: the counter array is a bank of flops, not a RAM, so it is reset element by
    // element; leaving it unreset would let a stale count shorten the first debounce.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn <= '0;
            for (int i = 0; i < BTN_BITS; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < BTN_BITS; i++) begin
                if (btn_sync[i] == btn[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    btn[i] <= btn_sync[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // NOTE: every signal driven here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        chord_nxt = chord;
        timer_nxt = timer;
        emit      = 1'b0;
        case (state)
            IDLE: begin
                if (btn != '0) begin
                    chord_nxt = btn;
                    timer_nxt = '0;
                    state_nxt = COLLECT;
                end
            end
            COLLECT: begin
                chord_nxt = chord | btn;
                if (timer == TMR_LAST || btn == '0) begin
                    emit      = 1'b1;
                    state_nxt = HOLD;
                end else begin
                    timer_nxt = timer + TMR_W'(1);
                end
            end
            HOLD: begin
                if (btn == '0) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Command fields are only loaded on emit so they stay readable after the pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            chord     <= '0;
            timer     <= '0;
            cmd_valid <= 1'b0;
            cmd_btn   <= '0;
            cmd_sw    <= '0;
        end else begin
            state     <= state_nxt;
            chord     <= chord_nxt;
            timer     <= timer_nxt;
            cmd_valid <= emit;
            if (emit) begin
                cmd_btn <= chord | btn;
                cmd_sw  <= sw;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_btn_cmd_frontend.sv
// Directed bench for btn_cmd_frontend with short debounce (4) and chord (8) windows.
module tb_btn_cmd_frontend;

    logic       clk;
    logic       rst_n;
    logic [3:0] btn_raw;
    logic [7:0] sw_raw;
    logic [3:0] btn;
    logic [7:0] sw;
    logic       cmd_valid;
    logic [3:0] cmd_btn;
    logic [7:0] cmd_sw;
    logic       busy;

    int total = 0;
    int bad   = 0;
    int pulse_cnt = 0;
    logic prev_valid = 1'b0;

    typedef struct {
        string      name;
        logic [3:0] btn_raw;
        logic [7:0] sw_raw;
        int         cycles;
        logic [3:0] exp_btn;
        logic       exp_busy;
        int         exp_pulses;
        logic [3:0] exp_cmd_btn;
        logic [7:0] exp_cmd_sw;
    } vec_t;

    vec_t vecs[$];

    btn_cmd_frontend #(
        .BTN_BITS       (4),
        .SW_BITS        (8),
        .DEBOUNCE_CYCLES(4),
        .CHORD_CYCLES   (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_raw  (btn_raw),
        .sw_raw   (sw_raw),
        .btn      (btn),
        .sw       (sw),
        .cmd_valid(cmd_valid),
        .cmd_btn  (cmd_btn),
        .cmd_sw   (cmd_sw),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cmd_valid === 1'b1) begin
            pulse_cnt++;
            check("no_back_to_back", 32'(prev_valid), 32'd0);
        end
        prev_valid = cmd_valid;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int   p0;
        int   btn_edge;
        int   pulse_edge;
        logic seen;

        btn_raw = '0;
        sw_raw  = '0;
        rst_n   = 1'b1;

        // Async reset must clear outputs before any clock edge.
        #3 rst_n = 1'b0;
        #1;
        check("reset_btn",       32'(btn),       32'd0);
        check("reset_sw",        32'(sw),        32'd0);
        check("reset_cmd_valid", 32'(cmd_valid), 32'd0);
        check("reset_cmd_btn",   32'(cmd_btn),   32'd0);
        check("reset_cmd_sw",    32'(cmd_sw),    32'd0);
        check("reset_busy",      32'(busy),      32'd0);

        // Test 1: exact latency of debounce and full chord window.
        repeat (2) @(negedge clk);
        btn_raw = 4'b0010;
        sw_raw  = 8'h5A;
        rst_n   = 1'b1;
        p0 = pulse_cnt;
        btn_edge   = -1;
        pulse_edge = -1;
        for (int e = 1; e <= 30; e++) begin
            @(negedge clk);
            #1;
            if (btn_edge < 0 && btn == 4'b0010) btn_edge = e;
            if (pulse_edge < 0 && cmd_valid) pulse_edge = e;
        end
        check("t1_btn_edge",   32'(btn_edge),          32'd6);
        check("t1_pulse_edge", 32'(pulse_edge),        32'd15);
        check("t1_pulses",     32'(pulse_cnt - p0),    32'd1);
        check("t1_cmd_btn",    32'(cmd_btn),           32'h2);
        check("t1_cmd_sw",     32'(cmd_sw),            32'h5A);
        check("t1_sw",         32'(sw),                32'h5A);
        check("t1_busy",       32'(busy),              32'd1);

        vecs.push_back('{"t1_release",   4'b0000, 8'h5A, 12, 4'b0000, 1'b0, 0, 4'b0010, 8'h5A});
        for (int k = 0; k < 5; k++) begin
            vecs.push_back('{"t2_bounce_hi", 4'b0010, 8'h5A, 3, 4'b0000, 1'b0, 0, 4'b0010, 8'h5A});
            vecs.push_back('{"t2_bounce_lo", 4'b0000, 8'h5A, 3, 4'b0000, 1'b0, 0, 4'b0010, 8'h5A});
        end
        vecs.push_back('{"t2_settle",    4'b0000, 8'h5A, 8,  4'b0000, 1'b0, 0, 4'b0010, 8'h5A});
        vecs.push_back('{"t3_first",     4'b1000, 8'hC3, 3,  4'b0000, 1'b0, 0, 4'b0010, 8'h5A});
        vecs.push_back('{"t3_chord",     4'b1001, 8'hC3, 30, 4'b1001, 1'b1, 1, 4'b1001, 8'hC3});
        vecs.push_back('{"t3_release",   4'b0000, 8'hC3, 12, 4'b0000, 1'b0, 0, 4'b1001, 8'hC3});
        vecs.push_back('{"t4_press",     4'b1000, 8'h3C, 6,  4'b1000, 1'b0, 0, 4'b1001, 8'hC3});
        vecs.push_back('{"t4_release",   4'b0000, 8'h3C, 15, 4'b0000, 1'b0, 1, 4'b1000, 8'h3C});
        vecs.push_back('{"t5_press",     4'b0100, 8'h11, 30, 4'b0100, 1'b1, 1, 4'b0100, 8'h11});
        vecs.push_back('{"t5_add",       4'b0110, 8'h11, 20, 4'b0110, 1'b1, 0, 4'b0100, 8'h11});
        vecs.push_back('{"t5_release",   4'b0000, 8'h11, 15, 4'b0000, 1'b0, 0, 4'b0100, 8'h11});
        vecs.push_back('{"t5_new",       4'b0010, 8'h22, 30, 4'b0010, 1'b1, 1, 4'b0010, 8'h22});
        vecs.push_back('{"t5_release2",  4'b0000, 8'h22, 15, 4'b0000, 1'b0, 0, 4'b0010, 8'h22});

        foreach (vecs[r]) begin
            btn_raw = vecs[r].btn_raw;
            sw_raw  = vecs[r].sw_raw;
            p0 = pulse_cnt;
            repeat (vecs[r].cycles) @(negedge clk);
            #1;
            check({vecs[r].name, "_btn"},     32'(btn),            32'(vecs[r].exp_btn));
            check({vecs[r].name, "_busy"},    32'(busy),           32'(vecs[r].exp_busy));
            check({vecs[r].name, "_pulses"},  32'(pulse_cnt - p0), 32'(vecs[r].exp_pulses));
            check({vecs[r].name, "_cmd_btn"}, 32'(cmd_btn),        32'(vecs[r].exp_cmd_btn));
            check({vecs[r].name, "_cmd_sw"},  32'(cmd_sw),         32'(vecs[r].exp_cmd_sw));
        end

        // Test 6: reset in the middle of COLLECT discards the chord.
        btn_raw = 4'b0100;
        sw_raw  = 8'h77;
        p0 = pulse_cnt;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            #1;
            if (busy) seen = 1'b1;
        end
        check("t6_busy_seen", 32'(seen), 32'd1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_btn",       32'(btn),       32'd0);
        check("t6_rst_sw",        32'(sw),        32'd0);
        check("t6_rst_busy",      32'(busy),      32'd0);
        check("t6_rst_cmd_valid", 32'(cmd_valid), 32'd0);
        check("t6_rst_cmd_btn",   32'(cmd_btn),   32'd0);
        check("t6_rst_cmd_sw",    32'(cmd_sw),    32'd0);
        check("t6_rst_pulses",    32'(pulse_cnt - p0), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pulse_edge = -1;
        for (int e = 1; e <= 30; e++) begin
            @(negedge clk);
            #1;
            if (pulse_edge < 0 && cmd_valid) pulse_edge = e;
        end
        check("t6_pulse_edge", 32'(pulse_edge),     32'd15);
        check("t6_pulses",     32'(pulse_cnt - p0), 32'd1);
        check("t6_cmd_btn",    32'(cmd_btn),        32'h4);
        check("t6_cmd_sw",     32'(cmd_sw),         32'h77);
        check("t6_busy",       32'(busy),           32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
